// File: rtl/ram_scan_pkg.sv
// Shared definitions for the RAM scan reader: FSM state encoding and pacing-counter sizing.
// The bench monitor imports the same state encoding.
package ram_scan_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_PRESENT = 3'd3,
        S_PACE    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Wide enough to hold PACE_CYCLES-1, and never narrower than one bit.
    function automatic int pace_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/ram_scan_reader_pace_counter.sv
// Down-counter that spaces consecutive items: load a start value, decrement while pacing,
// and report when it has reached zero.
module pace_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // clear (abort) has priority over load, and the count saturates at zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side master for the shared single-port RAM: sweeps addresses 0..DEPTH-1 and streams
// each (address, word) pair to a downstream consumer over a valid/ready handshake.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 4,
    parameter int DEPTH       = 32,
    parameter int PACE_CYCLES = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int                PACE_W    = pace_width(PACE_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(PACE_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_cnt_next;
    logic [ADDR_W-1:0] out_addr_next;
    logic [DATA_W-1:0] out_data_next;
    logic              out_valid_next;
    logic              done_next;
    logic              pace_load;
    logic              pace_dec;
    logic              pace_zero;
    logic              handshake;
    logic              at_last;

    assign handshake = (state == S_PRESENT) && out_valid && out_ready;
    assign at_last   = (addr_cnt == LAST_ADDR);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // stop overrides everything, including a start arriving in the same cycle.
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state_next = S_ISSUE;
                S_ISSUE:   state_next = S_CAPTURE;
                S_CAPTURE: state_next = S_PRESENT;
                S_PRESENT: if (handshake) state_next = (at_last && !continuous) ? S_DONE : S_PACE;
                S_PACE:    if (pace_zero) state_next = S_ISSUE;
                S_DONE:    state_next = S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    // The RAM registers addr_cnt at the ISSUE edge, so ram_q is valid throughout CAPTURE.
    always_comb begin
        addr_cnt_next  = addr_cnt;
        out_addr_next  = out_addr;
        out_data_next  = out_data;
        out_valid_next = out_valid;
        pace_load      = 1'b0;
        pace_dec       = 1'b0;
        done_next      = (state_next == S_DONE);
        if (stop) begin
            addr_cnt_next  = '0;
            out_valid_next = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) addr_cnt_next = '0;
                end
                S_CAPTURE: begin
                    out_data_next  = ram_q;
                    out_addr_next  = addr_cnt;
                    out_valid_next = 1'b1;
                end
                S_PRESENT: begin
                    if (handshake) begin
                        out_valid_next = 1'b0;
                        pace_load      = 1'b1;
                        addr_cnt_next  = at_last ? '0 : addr_cnt + ADDR_W'(1);
                    end
                end
                S_PACE: begin
                    pace_dec = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_cnt  <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            addr_cnt  <= addr_cnt_next;
            out_addr  <= out_addr_next;
            out_data  <= out_data_next;
            out_valid <= out_valid_next;
            done      <= done_next;
        end
    end

    pace_counter #(
        .WIDTH (PACE_W)
    ) u_pace_counter (
        .clock      (clock),
        .resetn     (resetn),
        .clear      (stop),
        .load       (pace_load),
        .load_value (PACE_LOAD),
        .dec        (pace_dec),
        .zero       (pace_zero)
    );

    assign ram_address = addr_cnt;
    assign ram_wren    = 1'b0;
    assign busy        = (state != S_IDLE);

endmodule
